neuron_mac: RTL and testbench
=============================

# neuron_mac

Sequential multiply-accumulate front end of a neuron. It streams N_IN input/weight pairs in Q8.24, adds a bias, and saturates the result to WIDTH bits. The registered sum becomes the pre-activation operand `a` for the downstream `tanh` stage, so the block sits directly upstream of the activation pipeline. It uses the same `en` stall semantics as the activation pipeline, so one enable can freeze the whole neuron.

## Interface
- WIDTH, 32, data width of x, w, bias and sum (signed two's complement)
- FL, 24, fractional bits (Q8.24 at defaults)
- N_IN, 4, number of input/weight pairs per neuron evaluation (2..256)
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  reset, asynchronous, active-low
- en  input  1  global stall; when low every register holds its value
- start  input  1  begin an evaluation; sampled only in IDLE with en high
- bias  input  WIDTH  bias; captured on the accepted start
- x_in  input  WIDTH  input activation sample
- w_in  input  WIDTH  weight paired with x_in
- in_valid  input  1  x_in/w_in pair presented
- in_ready  output  1  pair accepted this cycle when in_valid & in_ready; combinational: (state==ACC) & en
- busy  output  1  state != IDLE (combinational from state register)
- sum_out  output  WIDTH  saturated pre-activation; feeds tanh `a`
- out_valid  output  1  sum_out newly valid (registered)

## Operation
- Accumulator `acc` is ACC_W = 2*WIDTH-FL+8 bits signed (48 at defaults). Counter `cnt` is ceil(log2(N_IN)) bits.
- Product: full signed 2*WIDTH multiply x_in*w_in. Take bits [2*WIDTH-1:FL], truncating toward −inf, and sign-extend to ACC_W. No overflow is possible for N_IN ≤ 256.
- FSM states are IDLE, ACC and SAT. All transitions require en high.
- IDLE, start high: acc <= sign_ext(bias), cnt <= 0, next state ACC. in_valid in IDLE is ignored. start alongside in_valid takes start only.
- ACC, in_valid high: acc <= acc + product, cnt <= cnt+1. If cnt == N_IN-1, next state SAT. in_valid low means no change, and gaps of any length are allowed.
- SAT: sum_out <= clamp(acc), out_valid <= 1, next state IDLE. clamp saturates at +max (0x7FFFFFFF) and −min (0x80000000); otherwise it passes acc[WIDTH-1:0].
- out_valid: set on the SAT edge and cleared on the next enabled edge, giving a one-cycle pulse. sum_out holds until the next SAT.
- start while busy: ignored, no queueing.
- en low: state, acc, cnt, sum_out and out_valid all hold. An out_valid pulse therefore stretches across a stall. in_ready is 0.
- Reset (any time, including mid-accumulation): state IDLE, acc 0, cnt 0, sum_out 0, out_valid 0. The partial sum is discarded.

## Timing
- Reset values: sum_out = 0, out_valid = 0, busy = 0, in_ready = 0.
- start accepted at edge t: in_ready is high from cycle t+1.
- Last pair accepted at edge k: SAT occupies cycle k+1; sum_out and out_valid are visible from cycle k+2; busy is low in cycle k+2.
- Minimum evaluation time is N_IN+2 cycles from the start edge to out_valid. The next start is accepted in the cycle out_valid is high.
- Downstream tanh adds 2 more cycles. When en is shared, total neuron latency is 4 cycles after the last pair, plus any stall cycles.

## Test plan
- Reset: assert rst=0 mid-stream with random inputs → all outputs 0, busy 0; after release, an evaluation with bias 0x00800000 and 4 × (x=0x01000000, w=0x00400000) yields 0x01800000.
- Basic: bias=0x00800000 (0.5), 4 × (x=0x01000000, w=0x00400000) back-to-back → out_valid exactly 2 cycles after the 4th accept, sum_out=0x01800000 (1.5), single-cycle pulse.
- Negative/truncation: bias=0, 4 × (x=0xFE000000 −2.0, w=0x00800000 0.5) → 0xFC000000 (−4.0). Then x=0xFFFFFFFF, w=0x00000001 → product −1 LSB (floor), sum 0xFFFFFFFF with bias 0 and the other pairs zero.
- Saturation: 4 × (x=0x40000000 64.0, w=0x04000000 4.0) → 0x7FFFFFFF. Same with w=0xFC000000 → 0x80000000.
- Stall and gaps: basic case with en=0 for 3 cycles during ACC (in_valid held high) and in_valid low for 2 cycles → in_ready 0 while stalled, no extra accepts, result 0x01800000. en=0 during out_valid stretches the pulse.
- Protocol: start pulsed while busy is ignored (result unchanged). start and in_valid together in IDLE → pair not counted. A back-to-back start in the out_valid cycle is accepted.

Source files
------------

// File: rtl/neuron_mac.sv
// neuron_mac: streamed Q8.24 multiply-accumulate with bias and output saturation
module neuron_mac #(
  parameter int WIDTH = 32,
  parameter int FL    = 24,
  parameter int N_IN  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] bias,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] w_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    busy,
  output logic signed [WIDTH-1:0] sum_out,
  output logic                    out_valid
);
  localparam int ACC_W = 2*WIDTH-FL+8;
  localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
  typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;
  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic        [CW-1:0]      cnt;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic                      fits;
  logic        [WIDTH-1:0]   clamp;
  assign prod     = x_in * w_in;
  // arithmetic shift floors the dropped fraction; the cast keeps the sign-extended low ACC_W bits
  assign prod_ext = ACC_W'(prod >>> FL);
  assign bias_ext = {{(ACC_W-WIDTH){bias[WIDTH-1]}}, bias};
  assign fits     = (&acc[ACC_W-1:WIDTH-1]) | ~(|acc[ACC_W-1:WIDTH-1]);
  assign clamp    = fits ? acc[WIDTH-1:0] :
                    acc[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign busy     = state != IDLE;
  assign in_ready = (state == ACC) & en;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sum_out   <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= state == SAT;
      case (state)
        IDLE: if (start) begin
          acc   <= bias_ext;
          cnt   <= '0;
          state <= ACC;
        end
        ACC: if (in_valid) begin
          acc <= acc + prod_ext;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N_IN-1)) state <= SAT;
        end
        default: begin
          sum_out <= clamp;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed checks of neuron_mac against hand-computed Q8.24 results
module tb_neuron_mac;
  logic        clk = 0, rst = 0, en = 1, start = 0, in_valid = 0;
  logic [31:0] bias = 0, x_in = 0, w_in = 0;
  logic        in_ready, busy, out_valid;
  logic [31:0] sum_out;
  int errors = 0, checks = 0;
  neuron_mac dut (.clk(clk), .rst(rst), .en(en), .start(start), .bias(bias), .x_in(x_in),
                  .w_in(w_in), .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
                  .sum_out(sum_out), .out_valid(out_valid));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic begin_eval(input logic [31:0] b);
    start = 1;
    bias  = b;
    step;
    start = 0;
  endtask
  task automatic feed(input logic [31:0] x, input logic [31:0] w);
    in_valid = 1;
    x_in = x;
    w_in = w;
    step;
    in_valid = 0;
  endtask
  task automatic feed4(input logic [31:0] x, input logic [31:0] w);
    for (int i = 0; i < 4; i++) feed(x, w);
  endtask
  // call right after the last accepted pair; optionally issue a new start in the out_valid cycle
  task automatic finish_eval(input string tag, input logic [31:0] exp, input logic nxt,
                             input logic [31:0] nb);
    chk({tag, "_sat_ov"}, out_valid, 0);
    chk({tag, "_sat_busy"}, busy, 1);
    step;
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_sum"}, sum_out, exp);
    chk({tag, "_busy"}, busy, 0);
    if (nxt) begin
      start = 1;
      bias  = nb;
    end
    step;
    start = 0;
    chk({tag, "_pulse"}, out_valid, 0);
    chk({tag, "_hold"}, sum_out, exp);
  endtask
  initial begin
    step;
    step;
    chk("rst_sum", sum_out, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", in_ready, 0);
    rst = 1;
    step;
    // reset in the middle of an accumulation
    begin_eval(32'h00800000);
    chk("start_rdy", in_ready, 1);
    feed($urandom, $urandom);
    feed($urandom, $urandom);
    rst = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", in_ready, 0);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_sum", sum_out, 0);
    step;
    rst = 1;
    step;
    begin_eval(32'h00800000);
    feed4(32'h01000000, 32'h00400000);
    finish_eval("after_rst", 32'h01800000, 0, 0);
    begin_eval(32'h00800000);
    feed4(32'h01000000, 32'h00400000);
    finish_eval("basic", 32'h01800000, 0, 0);
    begin_eval(0);
    feed4(32'hFE000000, 32'h00800000);
    finish_eval("neg", 32'hFC000000, 0, 0);
    begin_eval(0);
    feed(32'hFFFFFFFF, 32'h00000001);
    feed(0, 0);
    feed(0, 0);
    feed(0, 0);
    finish_eval("floor", 32'hFFFFFFFF, 0, 0);
    begin_eval(0);
    feed4(32'h40000000, 32'h04000000);
    finish_eval("sat_pos", 32'h7FFFFFFF, 0, 0);
    begin_eval(0);
    feed4(32'h40000000, 32'hFC000000);
    finish_eval("sat_neg", 32'h80000000, 0, 0);
    // stall and gaps during accumulation
    begin_eval(32'h00800000);
    feed(32'h01000000, 32'h00400000);
    in_valid = 1;
    en = 0;
    #1;
    chk("stall_rdy", in_ready, 0);
    step;
    step;
    step;
    chk("stall_busy", busy, 1);
    en = 1;
    step;
    in_valid = 0;
    step;
    step;
    feed(32'h01000000, 32'h00400000);
    chk("gap_busy", busy, 1);
    feed(32'h01000000, 32'h00400000);
    chk("gap_sat_ov", out_valid, 0);
    step;
    chk("gap_ov", out_valid, 1);
    chk("gap_sum", sum_out, 32'h01800000);
    en = 0;
    step;
    step;
    chk("stretch_ov", out_valid, 1);
    en = 1;
    step;
    chk("stretch_end", out_valid, 0);
    // start while busy is ignored
    begin_eval(32'h00800000);
    feed(32'h01000000, 32'h00400000);
    feed(32'h01000000, 32'h00400000);
    start = 1;
    bias  = 32'h7F000000;
    feed(32'h01000000, 32'h00400000);
    start = 0;
    feed(32'h01000000, 32'h00400000);
    finish_eval("busy_start", 32'h01800000, 1, 0);
    // the start issued in the out_valid cycle above is running now
    chk("b2b_busy", busy, 1);
    feed4(32'hFE000000, 32'h00800000);
    finish_eval("b2b", 32'hFC000000, 0, 0);
    // start with in_valid in IDLE: the pair is not counted
    in_valid = 1;
    x_in = 32'h10000000;
    w_in = 32'h10000000;
    begin_eval(32'h00800000);
    in_valid = 0;
    feed(32'h01000000, 32'h00400000);
    feed(32'h01000000, 32'h00400000);
    feed(32'h01000000, 32'h00400000);
    chk("idle_pair_busy", busy, 1);
    chk("idle_pair_ov", out_valid, 0);
    feed(32'h01000000, 32'h00400000);
    finish_eval("idle_pair", 32'h01800000, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
